// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite bus bundle between a master and the ahb_slave_mem responder
interface ahb_slave_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite word memory responder with wait states; AHB_SLV_ERR_EN builds the two-cycle ERROR response
module ahb_slave_mem #(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 0
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_slave_mem_if.slave bus
);
  localparam bit         HAS_WAIT = WAIT_STATES > 0;
  localparam logic [3:0] WS_LOAD  = 4'(HAS_WAIT ? WAIT_STATES - 1 : 0);
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef AHB_SLV_ERR_EN
    , S_ERR1,
    S_ERR2
`endif
  } state_t;
  state_t            state_q, state_d, acc_d;
  logic [3:0]        cnt_q;
  logic [MEM_AW+1:0] addr_q;
  logic [2:0]        size_q;
  logic              write_q, err_q;
  logic              accept, err, we;
  logic [3:0]        lane;
  logic [MEM_AW-1:0] idx;
  logic [31:0]       mem [2**MEM_AW];
  logic              unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};
  assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] && bus.HREADYOUT;
  assign err = (bus.HADDR[31:MEM_AW+2] != '0) || (bus.HSIZE > 3'd2) ||
               (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
               (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
`ifdef AHB_SLV_ERR_EN
  assign acc_d = !accept ? S_IDLE : err ? S_ERR1 : HAS_WAIT ? S_WAIT : S_DATA;
`else
  assign acc_d = !accept ? S_IDLE : HAS_WAIT ? S_WAIT : S_DATA;
`endif
  assign idx  = addr_q[MEM_AW+1:2];
  assign lane = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign we   = HRESETn && state_q == S_DATA && write_q && !err_q;
  // State register and wait counter; the counter reloads outside WAIT so it is primed on entry
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_q == S_WAIT ? cnt_q - 4'd1 : WS_LOAD;
    end
  end
  // Next state: ready states follow the accept decision, WAIT counts down, ERR1 always steps to ERR2
  always_comb begin
    state_d = acc_d;
    if (state_q == S_WAIT) state_d = cnt_q == 4'd0 ? S_DATA : S_WAIT;
`ifdef AHB_SLV_ERR_EN
    if (state_q == S_ERR1) state_d = S_ERR2;
`endif
  end
  // Outputs decoded from state; read data only during a clean read data phase
  always_comb begin
    bus.HREADYOUT = state_q != S_WAIT;
    bus.HRESP     = 1'b0;
`ifdef AHB_SLV_ERR_EN
    bus.HREADYOUT = state_q != S_WAIT && state_q != S_ERR1;
    bus.HRESP     = state_q == S_ERR1 || state_q == S_ERR2;
`endif
    bus.HRDATA = state_q == S_DATA && !write_q && !err_q ? mem[idx] : '0;
  end
  // Capture the address phase of each accepted transfer
  always_ff @(posedge HCLK) begin
    if (accept) begin
      addr_q  <= bus.HADDR[MEM_AW+1:0];
      size_q  <= bus.HSIZE;
      write_q <= bus.HWRITE;
      err_q   <= err;
    end
  end
  // Commit write lanes at the edge that ends the write data phase
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (we && lane[i]) mem[idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed vectors against a zero-wait and a two-wait-state memory
module tb_ahb_slave_mem;
`ifdef AHB_SLV_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        rdy;
    logic        resp;
    logic [31:0] rd;
  } vec_t;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        sel0 = 1'b0, sel2 = 1'b0, wr = 1'b0;
  logic [1:0]  trans = TI;
  logic [2:0]  size = 3'd2;
  logic [31:0] addr = '0, wdata = '0;
  int          total = 0, bad = 0;
  vec_t        v[$];

  ahb_slave_mem_if b0();
  ahb_slave_mem_if b2();
  assign b0.HSEL = sel0;  assign b2.HSEL = sel2;
  assign b0.HADDR = addr;  assign b2.HADDR = addr;
  assign b0.HTRANS = trans; assign b2.HTRANS = trans;
  assign b0.HWRITE = wr;   assign b2.HWRITE = wr;
  assign b0.HSIZE = size;  assign b2.HSIZE = size;
  assign b0.HBURST = 3'd3; assign b2.HBURST = 3'd0;
  assign b0.HWDATA = wdata; assign b2.HWDATA = wdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b2.HREADY = b2.HREADYOUT;

  ahb_slave_mem #(.MEM_AW(8), .WAIT_STATES(0)) u0 (.HCLK(clk), .HRESETn(rstn), .bus(b0));
  ahb_slave_mem #(.MEM_AW(8), .WAIT_STATES(2)) u2 (.HCLK(clk), .HRESETn(rstn), .bus(b2));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] t, logic w, logic [2:0] s, logic [31:0] a,
                              logic [31:0] d, logic r, logic e, logic [31:0] q);
    vec_t x;
    x.tr = t; x.wr = w; x.sz = s; x.ad = a; x.wd = d; x.rdy = r; x.resp = e; x.rd = q;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic cyc(input logic s0, input logic s2, input logic [1:0] t, input logic w,
                     input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sel0 = s0; sel2 = s2; trans = t; wr = w; size = s; addr = a; wdata = d;
    #1;
  endtask

  task automatic chk2(input string n, input logic r, input logic e, input logic [31:0] q);
    chk({n, "_rdy"}, b2.HREADYOUT, r);
    chk({n, "_resp"}, b2.HRESP, e);
    chk({n, "_rd"}, b2.HRDATA, q);
  endtask

  initial begin
    v.push_back(mk(TN, 1, 2, 32'h10, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TN, 0, 2, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, 0, 32'hDEADBEEF));
    v.push_back(mk(TN, 1, 2, 32'h20, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TN, 1, 0, 32'h22, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TN, 1, 1, 32'h20, 32'h00AB0000, 1, 0, 32'h0));
    v.push_back(mk(TN, 0, 2, 32'h20, 32'h00001234, 1, 0, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, 0, 32'h00AB1234));
    v.push_back(mk(TN, 1, 2, 32'h40, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TS, 1, 2, 32'h44, 32'h1,        1, 0, 32'h0));
    v.push_back(mk(TS, 1, 2, 32'h48, 32'h2,        1, 0, 32'h0));
    v.push_back(mk(TS, 1, 2, 32'h4C, 32'h3,        1, 0, 32'h0));
    v.push_back(mk(TN, 0, 2, 32'h40, 32'h4,        1, 0, 32'h0));
    v.push_back(mk(TS, 0, 2, 32'h44, 32'h0,        1, 0, 32'h1));
    v.push_back(mk(TS, 0, 2, 32'h48, 32'h0,        1, 0, 32'h2));
    v.push_back(mk(TS, 0, 2, 32'h4C, 32'h0,        1, 0, 32'h3));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, 0, 32'h4));
    v.push_back(mk(TN, 0, 2, 32'h400, 32'h0,       1, 0, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        !ERR, ERR, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, ERR, 32'h0));
    v.push_back(mk(TN, 1, 2, 32'h42, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'hFFFFFFFF, !ERR, ERR, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, ERR, 32'h0));
    v.push_back(mk(TN, 0, 2, 32'h40, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, 0, 32'h1));
    v.push_back(mk(TN, 0, 3, 32'h40, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        !ERR, ERR, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, ERR, 32'h0));
    v.push_back(mk(TB, 0, 2, 32'h40, 32'h0,        1, 0, 32'h0));
    v.push_back(mk(TI, 0, 2, 32'h0,  32'h0,        1, 0, 32'h0));

    repeat (2) @(negedge clk);
    chk("rst0_rdy", b0.HREADYOUT, 1'b1);
    chk("rst0_resp", b0.HRESP, 1'b0);
    chk("rst0_rd", b0.HRDATA, 32'h0);
    chk2("rst2", 1, 0, 32'h0);
    rstn = 1'b1;

    foreach (v[i]) begin
      cyc(1, 0, v[i].tr, v[i].wr, v[i].sz, v[i].ad, v[i].wd);
      chk($sformatf("v%0d_rdy", i), b0.HREADYOUT, v[i].rdy);
      chk($sformatf("v%0d_resp", i), b0.HRESP, v[i].resp);
      chk($sformatf("v%0d_rd", i), b0.HRDATA, v[i].rd);
    end

    cyc(0, 1, TN, 1, 2, 32'h50, 32'h0);        chk2("w_idle", 1, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h11111111);  chk2("w_ws1", 0, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h11111111);  chk2("w_ws2", 0, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h11111111);  chk2("w_data", 1, 0, 32'h0);
    cyc(0, 1, TN, 0, 2, 32'h50, 32'h0);        chk2("r_idle", 1, 0, 32'h0);
    cyc(0, 1, TN, 0, 2, 32'h50, 32'h0);        chk2("r_ws1", 0, 0, 32'h0);
    cyc(0, 1, TN, 0, 2, 32'h50, 32'h0);        chk2("r_ws2", 0, 0, 32'h0);
    cyc(0, 1, TN, 0, 2, 32'h50, 32'h0);        chk2("r_data", 1, 0, 32'h11111111);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h0);         chk2("p_ws1", 0, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h0);         chk2("p_ws2", 0, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h0);         chk2("p_data", 1, 0, 32'h11111111);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h0);         chk2("p_idle", 1, 0, 32'h0);

    cyc(0, 1, TN, 1, 2, 32'h50, 32'h0);        chk2("x_idle", 1, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h22222222);  chk2("x_ws1", 0, 0, 32'h0);
    rstn = 1'b0;
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h22222222);  chk2("x_rst", 1, 0, 32'h0);
    rstn = 1'b1;
    cyc(0, 1, TN, 0, 2, 32'h50, 32'h0);        chk2("y_idle", 1, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h0);         chk2("y_ws1", 0, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h0);         chk2("y_ws2", 0, 0, 32'h0);
    cyc(0, 1, TI, 0, 2, 32'h0, 32'h0);         chk2("y_data", 1, 0, 32'h11111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite 3 responder: word-organised on-chip memory on the far end of the master's bus.
- Accepts SINGLE and INCR/WRAP burst transfers of byte, halfword and word size.
- Inserts a configurable number of wait states.
- Returns OKAY or a two-cycle ERROR response.
- Gives the master and its instruction stream a real target, in place of a behavioural stub.

Parameters:
- MEM_AW, 8, log2 of memory depth in 32-bit words (256 words = 1 KiB byte space).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in each OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock, all logic on rising edge
- HRESETn  in  1  synchronous active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=halfword, 2=word
- HBURST  in  3  burst type; accepted, not used for addressing
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus-level ready (mux output)
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Single clock HCLK. Synchronous active-low reset HRESETn, sampled on the rising edge of HCLK.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Address phase accept: an address phase is valid when HSEL && HREADY && HTRANS[1] at a rising edge. On accept, register addr_q, size_q and write_q.
- IDLE/BUSY or unselected transfers: not accepted, no memory access. FSM goes to or stays in IDLE with HREADYOUT=1, HRESP=0.
- Error check, done at accept:
  - HADDR[31:MEM_AW+2] != 0, or
  - HSIZE > 2, or
  - halfword with HADDR[0]=1, or
  - word with HADDR[1:0] != 0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE:
  - valid accept without error: to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else to DATA.
  - valid accept with error: to ERR1.
  - HREADYOUT=1.
- WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0, go to DATA.
- DATA: HREADYOUT=1, HRESP=0. Transfer completes this cycle. A new valid accept in the same cycle (pipelined) follows the IDLE transition rules. Otherwise go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2. No accept is possible, since HREADY is low.
- ERR2: HREADYOUT=1, HRESP=1. New accept allowed, same rules as IDLE. No memory access for the errored transfer.
- Write: in DATA, on the rising edge ending the phase, write HWDATA byte lanes selected by size_q and addr_q[1:0], little-endian:
  - byte: lane addr_q[1:0]
  - halfword: lanes {addr_q[1],0} and {addr_q[1],1}
  - word: all four lanes.
- Read:
  - HRDATA = mem[addr_q[MEM_AW+1:2]] (full word, combinational from array) while FSM is in DATA with write_q=0.
  - HRDATA = 0 otherwise. The master extracts lanes.
- Read-after-write to the same address back-to-back returns the new data, because the write commits at the edge that ends the previous data phase.
- Latency: read/write data phase of 1 + WAIT_STATES cycles after address accept.
- Reset asserted mid-WAIT or mid-ERR: at that edge the FSM returns to IDLE, outputs go to reset values, and the pending write is dropped.

Optional Feature:
AHB_SLV_ERR_EN
- Defined: error conditions produce the ERR1/ERR2 two-cycle ERROR response described above.
- Undefined: ERR1/ERR2 are not built. Erroring transfers take the normal OKAY path (including wait states), writes are dropped, reads return HRDATA=0, and HRESP is tied to 0.

Test Plan:
- Word write/read, WAIT_STATES=0: NONSEQ write 0x0000_0010 with HWDATA=0xDEADBEEF, then NONSEQ read 0x10 -> HRDATA=0xDEADBEEF in the read data phase, HREADYOUT=1 throughout, HRESP=0.
- Byte/halfword lanes: write word 0 at 0x20; byte write 0x22 with HWDATA=0x00AB0000; halfword write 0x20 with HWDATA=0x00001234 -> word read 0x20 returns 0x00AB1234.
- Wait states, WAIT_STATES=2: single read -> HREADYOUT low for exactly 2 cycles, then high with valid data. A pipelined second address is held by the master and accepted only in the HREADY=1 cycle.
- INCR4 word burst at 0x40 writing 1,2,3,4, then INCR4 read -> returns 1,2,3,4 on consecutive cycles, no bubbles at WAIT_STATES=0.
- Error (AHB_SLV_ERR_EN defined): read 0x0000_0400 (out of range, MEM_AW=8) -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE. Misaligned word write 0x42 -> same response and memory unchanged. With the macro undefined -> OKAY and HRDATA=0.
- Reset mid-operation: assert HRESETn=0 during the WAIT of a write to 0x50 -> next edge HREADYOUT=1, HRESP=0, HRDATA=0. Later read of 0x50 returns the prior contents.
